overlay_prefetch: RTL and testbench
===================================

Name: overlay_prefetch

Overview:
- Feeds the overlay blend stage with overlay pixels fetched from a 32-bit memory read port, a whole overlay image per frame.
- Buffers pixels in a small show-ahead FIFO and presents the head pixel on overlay0/1/2/A.
- Pops one pixel per overlay_adv. Flushes and refetches from base_addr on each overlay_restart.
- Sits between the frame-buffer arbiter and the overlay blend stage.

Parameters:
PIXEL_WIDTH, 8, width of each colour channel; fixed at 8.
ALPHA_WIDTH, 8, width of the alpha channel; fixed at 8.
ADDR_WIDTH, 24, width of the memory word address.
CNT_WIDTH, 22, width of the pixel count (covers rows*cols of 11-bit dimensions).
DEPTH, 8, FIFO depth in pixels; power of two, 2..64.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; low flushes the block and stops fetching
base_addr  input  ADDR_WIDTH  word address of the first overlay pixel
num_pixels  input  CNT_WIDTH  overlay pixels per frame (num_overlay_rows*num_overlay_cols)
mem_req  output  1  read request
mem_addr  output  ADDR_WIDTH  read word address
mem_ack  input  1  request accepted; mem_data valid in the same cycle
mem_data  input  32  pixel word: [7:0]=ch0, [15:8]=ch1, [23:16]=ch2, [31:24]=alpha
overlay_adv  input  1  pop the head pixel
overlay_restart  input  1  frame sync; flush and restart the fetch
overlay0  output  PIXEL_WIDTH  head pixel, channel 0
overlay1  output  PIXEL_WIDTH  head pixel, channel 1
overlay2  output  PIXEL_WIDTH  head pixel, channel 2
overlayA  output  ALPHA_WIDTH  head pixel alpha
underflow  output  1  sticky flag: a pop arrived while the FIFO was empty
underflow_clear  input  1  clears underflow

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: mem_req=0, mem_addr=0, underflow=0, FIFO empty, overlay0/1/2/A=0. Reset clears all counters and flags, including a pending discard.
- Reset mid-transaction drops the request. The memory side shares the same reset.
- Outputs:
  - FIFO non-empty: outputs are registered copies of the FIFO head.
  - FIFO empty: outputs are 0, so overlayA=0 (transparent).
- Handshake:
  - At most one request outstanding.
  - Once mem_req is high, mem_req and mem_addr hold stable until the cycle mem_ack=1.
  - mem_ack while mem_req=0 is ignored.
- Request rule: a new request is issued only when all of the following hold:
  - enable=1,
  - no request outstanding and no discard pending,
  - fetched < num_pixels,
  - fifo_count + 1 <= DEPTH, counting the word about to be requested.
- Back-to-back requests are allowed: mem_req stays high across an ack cycle if the conditions still hold, with mem_addr incremented.
- Fetch counting: on an accepted ack, mem_addr and fetched both increment by 1. mem_addr wraps modulo 2^ADDR_WIDTH.
- Ack latency: a word acked in cycle N is written to the FIFO and appears on the outputs in cycle N+1.
- Pop on a non-empty FIFO:
  - overlay_adv in cycle N pops the head; the next head (or zeros) appears in cycle N+1.
  - consumed increments.
- Pop on an empty FIFO:
  - If consumed < num_pixels: underflow is set, consumed increments, and skip increments. The next `skip` acked words are dropped, not written, each decrementing skip. This keeps pixel alignment with the raster.
  - If consumed >= num_pixels: the pop is ignored, with no flag.
- Simultaneous push and pop:
  - Non-empty FIFO: both take effect; count is unchanged.
  - Empty FIFO: treated as an underflow pop. The arriving word is counted against the new skip and dropped.
- overlay_restart, when enable=1:
  - Empties the FIFO and clears fetched, consumed and skip.
  - Loads mem_addr from base_addr; the first request is raised in the next cycle.
  - Overrides a same-cycle overlay_adv or ack-push.
  - If a request is outstanding and not acked this cycle, mem_req stays high until ack. That data is discarded (discard pending), then fetching restarts from base_addr.
- enable=0:
  - No new requests; an outstanding request completes and its data is discarded.
  - FIFO is flushed, outputs read 0, counters are cleared.
  - overlay_adv and overlay_restart are ignored.
  - underflow holds its value.
- underflow_clear clears underflow. A same-cycle underflow event wins, so the flag stays 1.
- Counter widths:
  - fifo_count has log2(DEPTH)+1 bits.
  - fetched, consumed and skip have CNT_WIDTH bits; skip never exceeds num_pixels.
- num_pixels=0: no requests are ever issued; all pops are ignored.

Test Plan:
1. num_pixels=4, base_addr=0x100, mem_ack one cycle after each request, words 0xFF112233+i:
   - requests go to 0x100..0x103, then mem_req stays low;
   - the first pixel appears one cycle after its ack with overlayA=0xFF, overlay2=0x11;
   - after 4 pops, outputs are 0.
2. DEPTH=8, num_pixels=20, no pops: exactly 8 acks, then mem_req=0 while full. One pop leads to exactly one new request to base_addr+8.
3. mem_ack held low for 5 cycles: mem_req and mem_addr are stable throughout. Pop while empty, num_pixels=4: underflow=1, the next acked word (addr+0) is dropped, and the following word (addr+1) reaches the head.
4. overlay_restart asserted while a request is outstanding (ack 3 cycles later): the acked word is discarded, the FIFO is empty, and the next request is to base_addr.
5. Pop and ack in the same cycle with 3 pixels buffered: fifo_count stays 3 and pixel order is preserved. underflow_clear in the same cycle as a new underflow leaves underflow=1.
6. Reset asserted mid-fetch with FIFO half full: the next cycle has mem_req=0, mem_addr=0, outputs 0 and underflow=0.

Source files
------------

// File: rtl/overlay_prefetch_if.sv
// Memory read port between overlay_prefetch (master) and the frame-buffer
// arbiter (slave). One request outstanding at a time; mem_data is valid in
// the same cycle as mem_ack.
interface overlay_prefetch_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [31:0]           mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/overlay_prefetch.sv
// Overlay pixel prefetcher: fetches one overlay image per frame from a 32-bit
// read port into a show-ahead FIFO and presents the head pixel to the blend
// stage. Pops on empty are counted so later words can be skipped, keeping the
// overlay aligned with the raster.
//
// Fetch FSM states:
//   state      | meaning
//   FS_IDLE    | no request outstanding
//   FS_REQ     | request outstanding, returned word belongs to this frame
//   FS_DISCARD | request outstanding, returned word is stale and dropped
module overlay_prefetch #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ALPHA_WIDTH = 8,
    parameter int ADDR_WIDTH  = 24,
    parameter int CNT_WIDTH   = 22,
    parameter int DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [CNT_WIDTH-1:0]   num_pixels,
    overlay_prefetch_if.master     mem,
    input  logic                   overlay_adv,
    input  logic                   overlay_restart,
    output logic [PIXEL_WIDTH-1:0] overlay0,
    output logic [PIXEL_WIDTH-1:0] overlay1,
    output logic [PIXEL_WIDTH-1:0] overlay2,
    output logic [ALPHA_WIDTH-1:0] overlayA,
    output logic                   underflow,
    input  logic                   underflow_clear
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0]      PTR_ONE   = 1;
    localparam logic [PTR_W:0]        FCNT_ONE  = 1;
    localparam logic [PTR_W:0]        FCNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_DISCARD
    } fetch_state_t;

    fetch_state_t state_q, state_d;

    logic [31:0]           fifo_q [DEPTH];
    logic [31:0]           fifo_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [CNT_WIDTH-1:0]  fetched_q, fetched_d;
    logic [CNT_WIDTH-1:0]  consumed_q, consumed_d;
    logic [CNT_WIDTH-1:0]  skip_q, skip_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           head_q, head_d;
    logic                  underflow_q, underflow_d;

    logic restart_en, flush, busy, ack, ack_keep;
    logic pop_req, pop, uf_evt, drop, push, issue;

    // Decode handshake, pop and skip events for this cycle
    always_comb begin
        restart_en = enable & overlay_restart;
        flush      = ~enable | restart_en;
        busy       = (state_q != FS_IDLE);
        ack        = busy & mem.mem_ack;
        ack_keep   = ack & (state_q == FS_REQ) & ~flush;
        pop_req    = enable & ~restart_en & overlay_adv;
        pop        = pop_req & (count_q != '0);
        uf_evt     = pop_req & (count_q == '0) & (consumed_q < num_pixels);
        // a word arriving with an underflow pop on an empty FIFO is the one
        // the new skip accounts for, so it is dropped straight away
        drop       = ack_keep & ((skip_q != '0) | uf_evt);
        push       = ack_keep & ~drop;
    end

    // FIFO, frame counters, head register and sticky underflow next state
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fetched_d   = fetched_q;
        consumed_d  = consumed_q;
        skip_d      = skip_q;
        head_d      = '0;
        underflow_d = uf_evt | (underflow_q & ~underflow_clear);

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetched_d  = '0;
            consumed_d = '0;
            skip_d     = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = mem.mem_data;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push & ~pop) begin
                count_d = count_q + FCNT_ONE;
            end else if (pop & ~push) begin
                count_d = count_q - FCNT_ONE;
            end
            if (ack_keep) begin
                fetched_d = fetched_q + CNT_ONE;
            end
            if (pop | uf_evt) begin
                consumed_d = consumed_q + CNT_ONE;
            end
            if (uf_evt & ~drop) begin
                skip_d = skip_q + CNT_ONE;
            end else if (drop & ~uf_evt) begin
                skip_d = skip_q - CNT_ONE;
            end
        end

        // next head: the word being pushed when it lands in the head slot
        if (count_d != '0) begin
            if (push && ((count_q == '0) || ((count_q == FCNT_ONE) && pop))) begin
                head_d = mem.mem_data;
            end else begin
                head_d = fifo_q[rd_ptr_d];
            end
        end
    end

    // Fetch FSM next state and request address
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        issue      = enable & (~busy | ack) & (fetched_d < num_pixels)
                     & (count_d < FCNT_FULL);

        if (busy & ~ack) begin
            // request and address stay frozen until the ack
            if (flush) begin
                state_d = FS_DISCARD;
            end
        end else begin
            state_d = issue ? FS_REQ : FS_IDLE;
            if (flush | (state_q == FS_DISCARD)) begin
                mem_addr_d = base_addr;
            end else if (ack_keep) begin
                mem_addr_d = mem_addr_q + ADDR_ONE;
            end
            // first word of a frame always comes from base_addr
            if (issue & (fetched_d == '0)) begin
                mem_addr_d = base_addr;
            end
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fetched_q   <= '0;
            consumed_q  <= '0;
            skip_q      <= '0;
            mem_addr_q  <= '0;
            head_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetched_q   <= fetched_d;
            consumed_q  <= consumed_d;
            skip_q      <= skip_d;
            mem_addr_q  <= mem_addr_d;
            head_q      <= head_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign mem.mem_req  = (state_q != FS_IDLE);
    assign mem.mem_addr = mem_addr_q;
    assign overlay0     = head_q[7:0];
    assign overlay1     = head_q[15:8];
    assign overlay2     = head_q[23:16];
    assign overlayA     = head_q[31:24];
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_overlay_prefetch.sv
// Directed bench for overlay_prefetch: the memory side is driven by hand,
// each step checks requests, addresses, head pixel and underflow.
module tb_overlay_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] base_addr;
    logic [21:0] num_pixels;
    logic        overlay_adv;
    logic        overlay_restart;
    logic [7:0]  overlay0, overlay1, overlay2, overlayA;
    logic        underflow;
    logic        underflow_clear;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    overlay_prefetch_if #(.ADDR_WIDTH(24)) mem_bus ();

    overlay_prefetch #(
        .PIXEL_WIDTH(8),
        .ALPHA_WIDTH(8),
        .ADDR_WIDTH (24),
        .CNT_WIDTH  (22),
        .DEPTH      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .base_addr      (base_addr),
        .num_pixels     (num_pixels),
        .mem            (mem_bus),
        .overlay_adv    (overlay_adv),
        .overlay_restart(overlay_restart),
        .overlay0       (overlay0),
        .overlay1       (overlay1),
        .overlay2       (overlay2),
        .overlayA       (overlayA),
        .underflow      (underflow),
        .underflow_clear(underflow_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] head();
        return {overlayA, overlay2, overlay1, overlay0};
    endfunction

    task automatic ack_word(input logic [31:0] d);
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_data = d;
        tick();
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b1;
        base_addr        = 24'h100;
        num_pixels       = 22'd4;
        overlay_adv      = 1'b0;
        overlay_restart  = 1'b0;
        underflow_clear  = 1'b0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;

        tick();
        tick();
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("rst_head", head(), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);

        // 1: four-pixel frame, ack one cycle after each request
        reset           = 1'b0;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        chk("t1_first_req", 32'(mem_bus.mem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", 32'(mem_bus.mem_addr), 32'h100 + 32'(i));
            tick();
            chk("t1_addr_hold", 32'(mem_bus.mem_addr), 32'h100 + 32'(i));
            chk("t1_req_hold", 32'(mem_bus.mem_req), 32'd1);
            ack_word(32'hFF112233 + 32'(i));
            if (i == 0) begin
                chk("t1_alpha", 32'(overlayA), 32'hFF);
                chk("t1_ch2", 32'(overlay2), 32'h11);
                chk("t1_head0", head(), 32'hFF112233);
            end
        end
        chk("t1_req_done", 32'(mem_bus.mem_req), 32'd0);
        tick();
        tick();
        chk("t1_req_idle", 32'(mem_bus.mem_req), 32'd0);
        overlay_adv = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t1_pop_head", head(), (j < 3) ? (32'hFF112234 + 32'(j)) : 32'd0);
        end
        tick();
        overlay_adv = 1'b0;
        chk("t1_pop_beyond_no_uf", 32'(underflow), 32'd0);

        // 2: FIFO fills to DEPTH, one pop releases exactly one request
        base_addr       = 24'h200;
        num_pixels      = 22'd20;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t2_req", 32'(mem_bus.mem_req), 32'd1);
            chk("t2_addr", 32'(mem_bus.mem_addr), 32'h200 + 32'(k));
            ack_word(32'hA0000000 + 32'(k));
        end
        chk("t2_full_req", 32'(mem_bus.mem_req), 32'd0);
        chk("t2_head", head(), 32'hA0000000);
        tick();
        tick();
        tick();
        chk("t2_full_idle", 32'(mem_bus.mem_req), 32'd0);
        overlay_adv = 1'b1;
        tick();
        overlay_adv = 1'b0;
        chk("t2_refill_req", 32'(mem_bus.mem_req), 32'd1);
        chk("t2_refill_addr", 32'(mem_bus.mem_addr), 32'h208);
        chk("t2_head_after_pop", head(), 32'hA0000001);
        ack_word(32'hA0000008);
        chk("t2_one_req_only", 32'(mem_bus.mem_req), 32'd0);

        // 3: stalled ack keeps request stable; underflow skips one word
        base_addr       = 24'h300;
        num_pixels      = 22'd4;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            overlay_adv = (i == 2);
            tick();
            chk("t3_req_stall", 32'(mem_bus.mem_req), 32'd1);
            chk("t3_addr_stall", 32'(mem_bus.mem_addr), 32'h300);
        end
        overlay_adv = 1'b0;
        chk("t3_uf_set", 32'(underflow), 32'd1);
        ack_word(32'hC0000000);
        chk("t3_dropped", head(), 32'd0);
        chk("t3_next_addr", 32'(mem_bus.mem_addr), 32'h301);
        ack_word(32'hC0000001);
        chk("t3_head_second", head(), 32'hC0000001);

        // 4: restart with a request outstanding discards its data
        chk("t4_pending_req", 32'(mem_bus.mem_req), 32'd1);
        base_addr       = 24'h400;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        chk("t4_req_held", 32'(mem_bus.mem_req), 32'd1);
        chk("t4_addr_held", 32'(mem_bus.mem_addr), 32'h302);
        chk("t4_flushed", head(), 32'd0);
        tick();
        tick();
        chk("t4_addr_still", 32'(mem_bus.mem_addr), 32'h302);
        ack_word(32'hDEAD0000);
        chk("t4_discarded", head(), 32'd0);
        chk("t4_req_base", 32'(mem_bus.mem_req), 32'd1);
        chk("t4_addr_base", 32'(mem_bus.mem_addr), 32'h400);

        // 5: simultaneous push and pop with three buffered pixels
        ack_word(32'hE0000000);
        ack_word(32'hE0000001);
        ack_word(32'hE0000002);
        chk("t5_head", head(), 32'hE0000000);
        chk("t5_addr", 32'(mem_bus.mem_addr), 32'h403);
        overlay_adv = 1'b1;
        ack_word(32'hE0000003);
        chk("t5_pushpop_head", head(), 32'hE0000001);
        chk("t5_req_done", 32'(mem_bus.mem_req), 32'd0);
        tick();
        chk("t5_pop2", head(), 32'hE0000002);
        tick();
        chk("t5_pop3", head(), 32'hE0000003);
        tick();
        overlay_adv = 1'b0;
        chk("t5_empty", head(), 32'd0);
        underflow_clear = 1'b1;
        tick();
        underflow_clear = 1'b0;
        chk("t5_uf_cleared", 32'(underflow), 32'd0);
        base_addr       = 24'h500;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        overlay_adv     = 1'b1;
        underflow_clear = 1'b1;
        tick();
        overlay_adv     = 1'b0;
        underflow_clear = 1'b0;
        chk("t5_uf_wins_clear", 32'(underflow), 32'd1);

        // 6: reset mid-fetch with the FIFO half full
        base_addr       = 24'h600;
        num_pixels      = 22'd20;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        ack_word(32'h0BAD0BAD);
        chk("t6_addr_base", 32'(mem_bus.mem_addr), 32'h600);
        for (int k = 0; k < 4; k++) begin
            ack_word(32'hF0000000 + 32'(k));
        end
        chk("t6_head", head(), 32'hF0000000);
        chk("t6_midfetch_addr", 32'(mem_bus.mem_addr), 32'h604);
        reset = 1'b1;
        tick();
        chk("t6_rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("t6_rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("t6_rst_head", head(), 32'd0);
        chk("t6_rst_uf", 32'(underflow), 32'd0);

        // disabled block: no requests, pops ignored
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        chk("dis_no_req", 32'(mem_bus.mem_req), 32'd0);
        overlay_adv = 1'b1;
        tick();
        overlay_adv = 1'b0;
        chk("dis_no_uf", 32'(underflow), 32'd0);

        // zero-size overlay: nothing fetched, pops ignored
        enable          = 1'b1;
        num_pixels      = 22'd0;
        overlay_restart = 1'b1;
        tick();
        overlay_restart = 1'b0;
        tick();
        chk("zero_no_req", 32'(mem_bus.mem_req), 32'd0);
        overlay_adv = 1'b1;
        tick();
        overlay_adv = 1'b0;
        chk("zero_no_uf", 32'(underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
